// File: rtl/core_issue_ctrl_if.sv
// Frontend-to-backend dual-slot issue handshake; slot 0 is the older instruction.
interface core_issue_ctrl_if;
   logic [1:0]      inst_valid;
   logic [1:0][4:0] r_reg0;
   logic [1:0][4:0] r_reg1;
   logic [1:0][4:0] w_reg;
   logic [1:0][1:0] lat;
   logic [1:0]      issue;

   modport master (output inst_valid, r_reg0, r_reg1, w_reg, lat, input issue);
   modport slave  (input inst_valid, r_reg0, r_reg1, w_reg, lat, output issue);
endinterface

// File: rtl/core_issue_ctrl.sv
// Dual-slot issue control: scoreboard RAW/WAW interlock, combinational accept, registered execute stage.
// Rejected slots are never buffered here; the frontend re-presents them.
module core_issue_ctrl #(
   parameter int NUM_ARCH_REG = 32,
   parameter int LAT_W        = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   core_issue_ctrl_if.slave     fe,
   input  logic                 stall_i,
   input  logic                 flush_i,
   input  logic                 wb_valid_i,
   input  logic [4:0]           wb_reg_i,
   output logic [1:0]           ex_valid_o,
   output logic [1:0][4:0]      ex_w_reg_o,
   output logic [31:0]          issued_cnt_o
);

   logic [NUM_ARCH_REG-1:0][LAT_W-1:0] cnt_q, cnt_d;
   logic [NUM_ARCH_REG-1:0]            lbusy_q, lbusy_d;
   logic [NUM_ARCH_REG-1:0]            busy;
   logic [1:0]                         ex_valid_q, ex_valid_d;
   logic [1:0][4:0]                    ex_w_reg_q, ex_w_reg_d;
   logic [31:0]                        issued_cnt_q, issued_cnt_d;
   logic                               s0_ok, s1_ok;
   logic                               pair_raw, pair_waw, both_long;
   logic [1:0]                         issue;

   // A count of 1 is the producer's final cycle: its result is bypassable, so dependents may go.
   always_comb begin
      busy = '0;
      for (int r = 1; r < NUM_ARCH_REG; r++) begin
         busy[r] = (cnt_q[r] > LAT_W'(1)) || lbusy_q[r];
      end
   end

   always_comb begin
      pair_raw  = (fe.w_reg[0] != 5'd0) &&
                  ((fe.w_reg[0] == fe.r_reg0[1]) || (fe.w_reg[0] == fe.r_reg1[1]));
      pair_waw  = (fe.w_reg[0] != 5'd0) && (fe.w_reg[0] == fe.w_reg[1]);
      both_long = (fe.lat[0] == 2'd0) && (fe.lat[1] == 2'd0);

      s0_ok = rst_n && fe.inst_valid[0] && !stall_i && !flush_i &&
              !busy[fe.r_reg0[0]] && !busy[fe.r_reg1[0]] && !busy[fe.w_reg[0]];
      s1_ok = s0_ok && fe.inst_valid[1] &&
              !busy[fe.r_reg0[1]] && !busy[fe.r_reg1[1]] && !busy[fe.w_reg[1]] &&
              !pair_raw && !pair_waw && !both_long;

      issue = {s1_ok, s0_ok};
   end

   assign fe.issue = issue;

   // Later assignments take priority: issue marks override writeback/flush clears and countdown.
   always_comb begin
      cnt_d   = cnt_q;
      lbusy_d = lbusy_q;
      for (int r = 0; r < NUM_ARCH_REG; r++) begin
         if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
      if (wb_valid_i) lbusy_d[wb_reg_i] = 1'b0;
      if (flush_i)    lbusy_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (issue[i] && (fe.w_reg[i] != 5'd0)) begin
            if (fe.lat[i] != 2'd0) cnt_d[fe.w_reg[i]]   = LAT_W'(fe.lat[i]);
            else                   lbusy_d[fe.w_reg[i]] = 1'b1;
         end
      end
      cnt_d[0]   = '0;
      lbusy_d[0] = 1'b0;
   end

   always_comb begin
      ex_valid_d = issue;
      ex_w_reg_d = ex_w_reg_q;
      for (int i = 0; i < 2; i++) begin
         if (issue[i]) ex_w_reg_d[i] = fe.w_reg[i];
      end
      issued_cnt_d = issued_cnt_q + {31'd0, issue[0]} + {31'd0, issue[1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         lbusy_q      <= '0;
         ex_valid_q   <= '0;
         ex_w_reg_q   <= '0;
         issued_cnt_q <= '0;
      end else begin
         cnt_q        <= cnt_d;
         lbusy_q      <= lbusy_d;
         ex_valid_q   <= ex_valid_d;
         ex_w_reg_q   <= ex_w_reg_d;
         issued_cnt_q <= issued_cnt_d;
      end
   end

   assign ex_valid_o   = ex_valid_q;
   assign ex_w_reg_o   = ex_w_reg_q;
   assign issued_cnt_o = issued_cnt_q;

endmodule
